// File: rtl/norm_factor_gen.sv
// norm_factor_gen: per-frame peak tracker with restoring divider yielding floor((2^FRAC_WIDTH-1)/peak)
module norm_factor_gen #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [INT_WIDTH-1:0]  s_pixel,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FRAC_WIDTH-1:0] m_norm_factor,
  output logic [INT_WIDTH-1:0]  m_peak
);
  localparam int CW = $clog2(FRAC_WIDTH);
  typedef enum logic [1:0] {ACC, DIV, DONE} state_t;
  state_t                state;
  logic [INT_WIDTH-1:0]  peak;
  logic [INT_WIDTH-1:0]  peak_nxt;
  logic [INT_WIDTH:0]    rem;
  logic [INT_WIDTH+1:0]  t;
  logic [INT_WIDTH:0]    diff;
  logic                  q_bit;
  logic [FRAC_WIDTH-2:0] quo;
  logic [FRAC_WIDTH-1:0] quo_nxt;
  logic [CW-1:0]         cnt;
  // peak doubles as the divisor: it cannot change outside ACC
  always_comb begin
    peak_nxt = s_pixel > peak ? s_pixel : peak;
    t        = {1'b0, rem, 1'b1};
    q_bit    = t >= {2'b00, peak};
    diff     = t[INT_WIDTH:0] - {1'b0, peak};
    quo_nxt  = {quo, q_bit};
  end
  assign s_ready = state == ACC;
  assign m_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACC;
      peak          <= '0;
      rem           <= '0;
      quo           <= '0;
      cnt           <= '0;
      m_norm_factor <= '0;
      m_peak        <= '0;
    end else begin
      case (state)
        ACC: if (s_valid) begin
          peak <= peak_nxt;
          if (s_last) begin
            state <= DIV;
            rem   <= '0;
            quo   <= '0;
            cnt   <= CW'(FRAC_WIDTH - 1);
          end
        end
        DIV: begin
          rem <= q_bit ? diff : t[INT_WIDTH:0];
          quo <= quo_nxt[FRAC_WIDTH-2:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state         <= DONE;
            m_norm_factor <= quo_nxt;
            m_peak        <= peak;
          end
        end
        default: if (m_ready) begin
          peak  <= '0;
          state <= ACC;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_norm_factor_gen.sv
// tb_norm_factor_gen: directed and randomized checks of the frame peak normalization factor
module tb_norm_factor_gen;
  logic        clk = 0;
  logic        rst = 1;
  logic        s_valid = 0;
  logic        s_ready;
  logic [7:0]  s_pixel = 0;
  logic        s_last = 0;
  logic        m_valid;
  logic        m_ready = 0;
  logic [15:0] m_norm_factor;
  logic [7:0]  m_peak;
  int errors = 0;
  int checks = 0;

  norm_factor_gen #(.INT_WIDTH(8), .FRAC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_norm_factor(m_norm_factor), .m_peak(m_peak)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] px, input logic last, input logic gap);
    int n = 0;
    s_valid = 1; s_pixel = px; s_last = last;
    while (!s_ready && n < 100) begin step(); n++; end
    step();
    s_valid = 0; s_last = 0;
    if (gap) begin s_pixel = 8'hff; step(); end
  endtask

  // call right after drive() of the last beat; returns cycles since the last beat, s_ready violations
  task automatic wait_result(output int lat, output int busy);
    lat = 1; busy = 0;
    while (!m_valid && lat < 100) begin
      if (s_ready) busy++;
      step(); lat++;
    end
  endtask

  task automatic handshake();
    m_ready = 1; step(); m_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    checks++;
    if (s_ready !== 1 || m_valid !== 0 || m_norm_factor !== 0 || m_peak !== 0) begin
      errors++;
      $display("FAIL reset: s_ready=%0b m_valid=%0b nf=%0d peak=%0d, want 1 0 0 0", s_ready, m_valid, m_norm_factor, m_peak);
    end
  endtask

  task automatic test_frame4();
    int lat, busy;
    drive(10, 0, 0); drive(200, 0, 0); drive(37, 0, 0); drive(200, 1, 0);
    wait_result(lat, busy);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL frame4_latency: got %0d want 17", lat); end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL frame4_s_ready_busy: s_ready high %0d cycles want 0", busy); end
    checks++;
    if (m_peak !== 200 || m_norm_factor !== 16'd327) begin
      errors++; $display("FAIL frame4_result: peak=%0d nf=%0d want 200 327", m_peak, m_norm_factor);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (m_valid !== 1 || s_ready !== 0 || m_norm_factor !== 16'd327 || m_peak !== 200) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%0b ready=%0b nf=%0d peak=%0d want 1 0 327 200", i, m_valid, s_ready, m_norm_factor, m_peak);
      end
    end
    handshake();
    checks++;
    if (m_valid !== 0 || s_ready !== 1) begin
      errors++; $display("FAIL hold_release: m_valid=%0b s_ready=%0b want 0 1", m_valid, s_ready);
    end
    checks++;
    if (m_norm_factor !== 16'd327 || m_peak !== 200) begin
      errors++; $display("FAIL hold_after_hs: nf=%0d peak=%0d want 327 200", m_norm_factor, m_peak);
    end
  endtask

  task automatic test_single();
    logic [7:0]  px [5] = '{255, 1, 3, 0, 5};
    logic [15:0] nf [5] = '{257, 65535, 21845, 65535, 13107};
    int lat, busy;
    for (int i = 0; i < 5; i++) begin
      drive(px[i], 1, 0);
      wait_result(lat, busy);
      checks++;
      if (lat !== 17 || m_peak !== px[i] || m_norm_factor !== nf[i]) begin
        errors++;
        $display("FAIL single_%0d: lat=%0d peak=%0d nf=%0d want 17 %0d %0d", px[i], lat, m_peak, m_norm_factor, px[i], nf[i]);
      end
      handshake();
    end
  endtask

  task automatic test_gapped();
    int lat, busy;
    m_ready = 1;
    drive(100, 0, 1); drive(0, 0, 1); drive(250, 1, 0);
    wait_result(lat, busy);
    checks++;
    if (lat !== 17 || m_peak !== 250 || m_norm_factor !== 16'd262) begin
      errors++; $display("FAIL gapped: lat=%0d peak=%0d nf=%0d want 17 250 262", lat, m_peak, m_norm_factor);
    end
    step();
    m_ready = 0;
    checks++;
    if (m_valid !== 0 || s_ready !== 1) begin
      errors++; $display("FAIL gapped_early_ready: m_valid=%0b s_ready=%0b want 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy;
    drive(200, 1, 0);
    for (int i = 0; i < 7; i++) step();
    rst = 1; step(); rst = 0;
    checks++;
    if (s_ready !== 1 || m_valid !== 0 || m_norm_factor !== 0 || m_peak !== 0) begin
      errors++; $display("FAIL reset_div: ready=%0b valid=%0b nf=%0d peak=%0d want 1 0 0 0", s_ready, m_valid, m_norm_factor, m_peak);
    end
    drive(200, 1, 0);
    wait_result(lat, busy);
    rst = 1; step(); rst = 0;
    checks++;
    if (s_ready !== 1 || m_valid !== 0 || m_norm_factor !== 0 || m_peak !== 0) begin
      errors++; $display("FAIL reset_done: ready=%0b valid=%0b nf=%0d peak=%0d want 1 0 0 0", s_ready, m_valid, m_norm_factor, m_peak);
    end
    drive(64, 1, 0);
    wait_result(lat, busy);
    checks++;
    if (lat !== 17 || m_peak !== 64 || m_norm_factor !== 16'd1023) begin
      errors++; $display("FAIL reset_then_64: lat=%0d peak=%0d nf=%0d want 17 64 1023", lat, m_peak, m_norm_factor);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat, busy, n, prod;
    logic [7:0]  p;
    logic [15:0] exp_nf;
    for (int f = 0; f < 200; f++) begin
      p = 8'($urandom_range(0, 255));
      exp_nf = p == 0 ? 16'hffff : 16'(65535 / p);
      drive(p, 1, 0);
      wait_result(lat, busy);
      checks++;
      if (lat !== 17 || m_peak !== p || m_norm_factor !== exp_nf) begin
        errors++; $display("FAIL random_%0d: lat=%0d peak=%0d nf=%0d want 17 %0d %0d", f, lat, m_peak, m_norm_factor, p, exp_nf);
      end
      prod = int'(m_peak) * int'(m_norm_factor);
      if (p != 0) begin
        checks++;
        if (prod > 65535 || (prod >> 8) != 255) begin
          errors++; $display("FAIL random_product_%0d: peak*nf=%0d want in [65280,65535]", f, prod);
        end
      end
      n = 0;
      m_ready = 1'($urandom_range(0, 1));
      while (!m_ready && n < 50) begin step(); n++; m_ready = 1'($urandom_range(0, 1)); end
      m_ready = 1;
      step();
      m_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_frame4();
    test_hold();
    test_single();
    test_gapped();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
